// File: rtl/falafel_lsu_pkg.sv
// Shared types for the falafel free-list load/store unit.
//   lsu_op_t          : 3-bit operation code (encoding 7 is undefined)
//   header_data_t     : block header {addr, size, next_addr}
//   header_data_req_t : {val, lsu_op, header_data}
//   header_data_rsp_t : {val, header_data}
package falafel_lsu_pkg;

  typedef logic [2:0] lsu_op_t;

  localparam lsu_op_t OpLock        = 3'd0;
  localparam lsu_op_t OpUnlock      = 3'd1;
  localparam lsu_op_t OpLoad        = 3'd2;
  localparam lsu_op_t OpUpdate      = 3'd3;
  localparam lsu_op_t OpFreeInsert  = 3'd4;
  localparam lsu_op_t OpAllocInsert = 3'd5;
  localparam lsu_op_t OpDelete      = 3'd6;

  // Byte offset of the next_addr word inside a block header.
  localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] size;
    logic [63:0] next_addr;
  } header_data_t;

  typedef struct packed {
    logic         val;
    lsu_op_t      lsu_op;
    header_data_t header_data;
  } header_data_req_t;

  typedef struct packed {
    logic         val;
    header_data_t header_data;
  } header_data_rsp_t;

endpackage

// File: rtl/falafel_lsu.sv
// Free-list load/store unit: turns one header-level request (lock, unlock, load, update,
// free/alloc insert, delete) into a short sequence of single-word memory accesses.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_i / req_ready_o   : request (req_i.val) and acceptance
//   rsp_o / rsp_err_o     : response (rsp_o.val), error flag qualified by rsp_o.val
//   rsp_ready_i           : response consumed
//   mem_*                 : single-outstanding word memory port (req/gnt, rvalid/rdata)
// Build option: define FALAFEL_LSU_LOCK_TIMEOUT_EN to abort a LOCK spin with an error after
// LOCK_RETRY_MAX consecutive nonzero lock reads; otherwise the spin is unbounded.
module falafel_lsu
  import falafel_lsu_pkg::*;
#(
  parameter logic [63:0] LOCK_ADDR      = 64'h0,
  parameter int unsigned LOCK_RETRY_MAX = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  header_data_req_t req_i,
  output logic             req_ready_o,
  output header_data_rsp_t rsp_o,
  output logic             rsp_err_o,
  input  logic             rsp_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [63:0]      mem_addr_o,
  output logic [63:0]      mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [63:0]      mem_rdata_i
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMemReq  = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;
  localparam logic [1:0] StRsp     = 2'd3;

  localparam int unsigned      RetryW   = $clog2(LOCK_RETRY_MAX + 2);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(LOCK_RETRY_MAX);

  logic [1:0]        state_q, state_d;
  // step 0 = size word (or lock read), step 1 = next_addr word (or lock write)
  logic              step_q, step_d;
  logic [RetryW-1:0] retry_q, retry_d, retry_inc;
  lsu_op_t           op_q, op_d;
  header_data_t      hd_q, hd_d;
  logic              err_q, err_d;
  // Low until the first edge after reset so ready rises on that edge.
  logic              init_q;
  logic              lock_op;

  assign lock_op   = (op_q == OpLock) || (op_q == OpUnlock);
  assign retry_inc = retry_q + RetryW'(1);

  function automatic logic op_legal(lsu_op_t op);
    case (op)
      OpLock, OpUnlock, OpLoad, OpUpdate, OpFreeInsert, OpAllocInsert, OpDelete: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    retry_d = retry_q;
    op_d    = op_q;
    hd_d    = hd_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_i.val && init_q) begin
          op_d    = req_i.lsu_op;
          hd_d    = req_i.header_data;
          retry_d = '0;
          // Single-write ops that touch only the second word start there directly.
          step_d  = (req_i.lsu_op == OpDelete) || (req_i.lsu_op == OpUnlock);
          err_d   = !op_legal(req_i.lsu_op);
          state_d = op_legal(req_i.lsu_op) ? StMemReq : StRsp;
        end
      end
      StMemReq: begin
        if (mem_gnt_i) state_d = StMemWait;
      end
      StMemWait: begin
        if (mem_rvalid_i) begin
          if (op_q == OpLoad) begin
            if (step_q) hd_d.next_addr = mem_rdata_i;
            else        hd_d.size      = mem_rdata_i;
          end
          if ((op_q == OpLock) && !step_q) begin
            if (mem_rdata_i == 64'h0) begin
              step_d  = 1'b1;
              retry_d = '0;
              state_d = StMemReq;
            end else begin
`ifdef FALAFEL_LSU_LOCK_TIMEOUT_EN
              if (retry_inc == RetryMax) begin
                err_d   = 1'b1;
                state_d = StRsp;
              end else begin
                retry_d = retry_inc;
                state_d = StMemReq;
              end
`else
              if (retry_q != RetryMax) retry_d = retry_inc;
              state_d = StMemReq;
`endif
            end
          end else if (step_q || (op_q == OpAllocInsert)) begin
            state_d = StRsp;
          end else begin
            step_d  = 1'b1;
            state_d = StMemReq;
          end
        end
      end
      StRsp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
    endcase
  end

`ifndef FALAFEL_LSU_LOCK_TIMEOUT_EN
  logic unused_retry;
  assign unused_retry = ^retry_q;
`endif

  always_comb begin
    mem_req_o   = (state_q == StMemReq);
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (lock_op) begin
        mem_addr_o  = LOCK_ADDR;
        mem_we_o    = step_q;
        mem_wdata_o = {63'd0, step_q && (op_q == OpLock)};
      end else begin
        mem_addr_o = step_q ? hd_q.addr + BLOCK_NEXT_ADDR_OFFSET : hd_q.addr;
        mem_we_o   = (op_q != OpLoad);
        if (mem_we_o) mem_wdata_o = step_q ? hd_q.next_addr : hd_q.size;
      end
    end
  end

  always_comb begin
    rsp_o.val         = (state_q == StRsp);
    rsp_o.header_data = rsp_o.val ? hd_q : '0;
    rsp_err_o         = rsp_o.val && err_q;
    req_ready_o       = (state_q == StIdle) && init_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      step_q  <= 1'b0;
      retry_q <= '0;
      op_q    <= '0;
      hd_q    <= '0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      retry_q <= retry_d;
      op_q    <= op_d;
      hd_q    <= hd_d;
      err_q   <= err_d;
      init_q  <= 1'b1;
    end
  end

endmodule

// File: doc/falafel_lsu.md
FALAFEL_LSU -- requirements
Module: falafel_lsu

Interface
REQ-001 SHALL have parameter LOCK_ADDR, default 64'h0: byte address of the global free-list lock word.
REQ-002 SHALL have parameter LOCK_RETRY_MAX, default 16: lock-spin read bound, used only when FALAFEL_LSU_LOCK_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk_i, input, 1: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_i, input, header_data_req_t: request; req_i.val is request-valid.
REQ-006 SHALL have port req_ready_o, output, 1: request accepted on the cycle where req_i.val and req_ready_o are both 1.
REQ-007 SHALL have port rsp_o, output, header_data_rsp_t: response; rsp_o.val is response-valid.
REQ-008 SHALL have port rsp_err_o, output, 1: error flag, qualified by rsp_o.val.
REQ-009 SHALL have port rsp_ready_i, input, 1: response consumed on the cycle where rsp_o.val and rsp_ready_i are both 1.
REQ-010 SHALL have memory ports: mem_req_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, 64), mem_wdata_o (out, 64), mem_gnt_i (in, 1), mem_rvalid_i (in, 1), mem_rdata_i (in, 64).

Function
REQ-011 SHALL serve one request at a time; req_ready_o = 1 only in state IDLE.
REQ-012 SHALL latch req_i.header_data and req_i.lsu_op on acceptance.
REQ-013 SHALL use states IDLE, MEM_REQ, MEM_WAIT, RSP; a step counter selects the current word access.
REQ-014 SHALL hold mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stable in MEM_REQ until mem_gnt_i = 1, then move to MEM_WAIT.
REQ-015 SHALL leave MEM_WAIT on mem_rvalid_i = 1 (reads and writes alike), capture mem_rdata_i on reads, then go to the next step or to RSP.
REQ-016 SHALL keep one memory transaction outstanding at most; mem_req_o = 0 outside MEM_REQ.
REQ-017 SHALL run LOCK as: read LOCK_ADDR; if the data is nonzero, repeat the read; if it is zero, write 64'h1 to LOCK_ADDR and respond.
REQ-018 SHALL run UNLOCK as: write 64'h0 to LOCK_ADDR and respond.
REQ-019 SHALL run LOAD as: read size at addr, then read next_addr at addr+BLOCK_NEXT_ADDR_OFFSET.
REQ-020 SHALL run UPDATE and FREE_INSERT as: write size at addr, then write next_addr at addr+BLOCK_NEXT_ADDR_OFFSET.
REQ-021 SHALL run ALLOC_INSERT as: write size at addr only.
REQ-022 SHALL run DELETE as: write next_addr at addr+BLOCK_NEXT_ADDR_OFFSET only.
REQ-023 SHALL compute addresses modulo 2^64 (wrap-around permitted, no error).
REQ-024 SHALL return in rsp_o.header_data the loaded {addr, size, next_addr} for LOAD, and the latched request for all other ops.
REQ-025 SHALL go directly from IDLE to RSP with rsp_err_o = 1 and no memory access when lsu_op is not one of the seven defined ops.
REQ-026 SHALL hold rsp_o stable in RSP while rsp_ready_i = 0, and return to IDLE on handshake; a new request is not accepted in that same cycle.
REQ-027 SHALL treat an empty request (addr = EMPTY_KEY) as a normal address.

Reset
REQ-028 SHALL, while rst_i = 1 (including mid-transaction), force: state IDLE, req_ready_o = 0, rsp_o = '0, rsp_err_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, step and retry counters = 0.
REQ-029 SHALL assert req_ready_o on the first clock edge after rst_i deasserts.

Configuration
REQ-030 SHALL, with FALAFEL_LSU_LOCK_TIMEOUT_EN defined, end the LOCK spin after LOCK_RETRY_MAX consecutive nonzero reads, with a response of rsp_err_o = 1 and no write.
REQ-031 SHALL, without FALAFEL_LSU_LOCK_TIMEOUT_EN, spin without bound and never set rsp_err_o for LOCK.

Verification
REQ-032 SHALL cover LOAD: addr=64'h1000, memory holds 64'h40 @1000 and 64'h2000 @1008 -> reads to 1000 then 1008; rsp {1000, 40, 2000}, err=0.
REQ-033 SHALL cover UPDATE: addr=64'h3000, size=64'h80, next=64'h0 -> writes 80 @3000 then 0 @3008, in order; rsp echoes the request.
REQ-034 SHALL cover LOCK contention: lock word reads 1, 1, 0 -> three reads, then a write of 1 @LOCK_ADDR, then rsp err=0.
REQ-035 SHALL cover LOCK timeout (macro defined, LOCK_RETRY_MAX=4, lock word stuck at 1) -> exactly 4 reads, no write, rsp err=1.
REQ-036 SHALL cover backpressure and reset: mem_gnt_i held low 5 cycles with mem outputs checked stable, rsp_ready_i held low 3 cycles with rsp_o checked stable, then rst_i pulsed in MEM_WAIT -> all outputs zero and IDLE afterwards.
REQ-037 SHALL cover an illegal op encoding 7 -> rsp err=1 one cycle after acceptance, with no mem_req_o.
